// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer
// Takes parallel words over a valid/ready handshake and emits them one bit per
// clock as a valid/bit stream for the downstream pattern detector. A one-word
// holding buffer lets the next word be queued while the current one shifts,
// so consecutive words come out with no gap cycles. `hold` pauses emission
// without dropping data.

module bit_stream_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             word_valid,
   input  logic [WIDTH-1:0] word_data,
   output logic             word_ready,
   input  logic             hold,
   output logic             bit_valid,
   output logic             bit_out,
   output logic             busy,
   output logic [CNT_W-1:0] words_sent
);

   localparam int CNT_IW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic [WIDTH-1:0]    sreg_reg, sreg_next;
   logic [CNT_IW-1:0]   cnt_reg, cnt_next;
   logic [WIDTH-1:0]    hbuf_reg, hbuf_next;
   logic                hfull_reg, hfull_next;
   logic [CNT_W-1:0]    words_sent_reg, words_sent_next;

   logic                active;
   logic                accept;
   logic                bit_fire;
   logic                last_bit;
   logic [WIDTH-1:0]    sreg_shifted;

   // Shifter contents after one bit has been consumed: everything moves one
   // place toward the output end and a zero enters at the far end.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
               assign sreg_shifted[gi] = 1'b0;
            end else begin : g_move
               assign sreg_shifted[gi] = sreg_reg[gi-1];
            end
         end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_fill
               assign sreg_shifted[gi] = 1'b0;
            end else begin : g_move
               assign sreg_shifted[gi] = sreg_reg[gi+1];
            end
         end
      end
   endgenerate

   // Handshake and stream outputs; everything reads as zero while reset is held.
   always_comb begin
      active     = (state_reg == ST_SHIFT);
      word_ready = rst & ~hfull_reg;
      accept     = word_valid & word_ready;
      bit_fire   = rst & active & ~hold;
      last_bit   = bit_fire & (cnt_reg == CNT_IW'(WIDTH - 1));
      bit_valid  = bit_fire;
      bit_out    = rst & sreg_reg[OUT_IDX];
      busy       = rst & (active | hfull_reg);
      words_sent = words_sent_reg;
   end

   // Next-state logic: shifter load/shift, holding buffer fill/drain, word count.
   always_comb begin
      state_next      = state_reg;
      sreg_next       = sreg_reg;
      cnt_next        = cnt_reg;
      hbuf_next       = hbuf_reg;
      hfull_next      = hfull_reg;
      words_sent_next = words_sent_reg;

      case (state_reg)
         ST_IDLE: begin
            // An idle shifter takes the word directly so its first bit
            // appears in the very next cycle.
            if (accept) begin
               sreg_next  = word_data;
               cnt_next   = '0;
               state_next = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (last_bit) begin
               words_sent_next = words_sent_reg + CNT_W'(1);
               cnt_next        = '0;
               if (hfull_reg) begin
                  // Queued word goes straight in behind the finished one.
                  sreg_next  = hbuf_reg;
                  hfull_next = 1'b0;
               end else if (accept) begin
                  // Nothing queued, but a word arrives exactly in time.
                  sreg_next = word_data;
               end else begin
                  sreg_next  = sreg_shifted;
                  state_next = ST_IDLE;
               end
            end else begin
               if (bit_fire) begin
                  sreg_next = sreg_shifted;
                  cnt_next  = cnt_reg + CNT_IW'(1);
               end
               // word_ready is low while the buffer is full, so an accept
               // here always lands in an empty buffer.
               if (accept) begin
                  hbuf_next  = word_data;
                  hfull_next = 1'b1;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset that discards any word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         sreg_reg       <= '0;
         cnt_reg        <= '0;
         hbuf_reg       <= '0;
         hfull_reg      <= 1'b0;
         words_sent_reg <= '0;
      end else begin
         state_reg      <= state_next;
         sreg_reg       <= sreg_next;
         cnt_reg        <= cnt_next;
         hbuf_reg       <= hbuf_next;
         hfull_reg      <= hfull_next;
         words_sent_reg <= words_sent_next;
      end
   end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: one MSB-first instance with a wide
// counter and one LSB-first instance with a 2-bit counter to reach the wrap.

module tb_bit_stream_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        hold;

   logic        mv, m_ready, m_bv, m_bo, m_busy;
   logic [7:0]  md;
   logic [15:0] m_ws;

   logic        lv, l_ready, l_bv, l_bo, l_busy;
   logic [7:0]  ld;
   logic [1:0]  l_ws;

   int n_tests = 0;
   int n_fail  = 0;

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
      .clk        (clk),
      .rst        (rst),
      .word_valid (mv),
      .word_data  (md),
      .word_ready (m_ready),
      .hold       (hold),
      .bit_valid  (m_bv),
      .bit_out    (m_bo),
      .busy       (m_busy),
      .words_sent (m_ws)
   );

   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(2)) u_lsb (
      .clk        (clk),
      .rst        (rst),
      .word_valid (lv),
      .word_data  (ld),
      .word_ready (l_ready),
      .hold       (hold),
      .bit_valid  (l_bv),
      .bit_out    (l_bo),
      .busy       (l_busy),
      .words_sent (l_ws)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Check 8 consecutive stream bits on the MSB-first instance; seq[7] comes first.
   task automatic expect_m(input string tag, input logic [7:0] seq);
      for (int i = 0; i < 8; i++) begin
         mid();
         check({tag, "_bv"}, m_bv, 1'b1);
         check({tag, "_bit"}, m_bo, seq[7-i]);
         step();
      end
   endtask

   initial begin
      logic [23:0] b2b;
      logic [10:0] hv, hb;
      logic [7:0]  lseq;
      int          accepts;
      bit          done;

      // ---------------- reset with word_valid asserted ----------------
      rst  = 1'b0;
      hold = 1'b0;
      mv   = 1'b1; md = 8'hFF;
      lv   = 1'b1; ld = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         mid();
         check("rst_ready", m_ready, 1'b0);
         check("rst_bv",    m_bv,    1'b0);
         check("rst_bo",    m_bo,    1'b0);
         check("rst_busy",  m_busy,  1'b0);
         check("rst_ws",    m_ws,    16'd0);
         check("rst_l_ready", l_ready, 1'b0);
         step();
      end
      rst = 1'b1;
      mv  = 1'b0;
      lv  = 1'b0;
      mid();
      check("rel_ready", m_ready, 1'b1);
      check("rel_busy",  m_busy,  1'b0);
      check("rel_bv",    m_bv,    1'b0);
      step();
      $display("[TB] reset sequence done");

      // ---------------- single word 8'h28 ----------------
      mv = 1'b1; md = 8'h28;
      mid();
      check("single_ready", m_ready, 1'b1);
      step();
      mv = 1'b0;
      expect_m("single", 8'b0010_1000);
      mid();
      check("single_end_bv",   m_bv,   1'b0);
      check("single_end_busy", m_busy, 1'b0);
      check("single_ws",       m_ws,   16'd1);
      step();
      $display("[TB] word 28 serialized");

      // ---------------- back-to-back A5, 3C, FF ----------------
      b2b = 24'hA5_3C_FF;
      mv = 1'b1; md = 8'hA5;
      mid();
      check("b2b_ready0", m_ready, 1'b1);
      step();
      md = 8'h3C;
      for (int i = 0; i < 24; i++) begin
         mid();
         check("b2b_bv",  m_bv, 1'b1);
         check("b2b_bit", m_bo, b2b[23-i]);
         if (i == 0) check("b2b_ready_2nd", m_ready, 1'b1);
         if (i == 1) check("b2b_ready_full", m_ready, 1'b0);
         if (i == 7) check("b2b_ready_still_full", m_ready, 1'b0);
         if (i == 8) check("b2b_ready_reload", m_ready, 1'b1);
         step();
         if (i == 0) md = 8'hFF;
         if (i == 8) mv = 1'b0;
      end
      mid();
      check("b2b_end_bv",   m_bv,   1'b0);
      check("b2b_end_busy", m_busy, 1'b0);
      check("b2b_ws",       m_ws,   16'd4);
      step();
      $display("[TB] words A5 3C FF serialized back-to-back");

      // ---------------- hold for 3 cycles after the 3rd bit of C3 ----------------
      hv = 11'b111_000_11111;
      hb = 11'b110_000_00011;
      mv = 1'b1; md = 8'hC3;
      mid();
      step();
      mv = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         hold = (c >= 4 && c <= 6);
         mid();
         check("hold_bv",  m_bv, hv[11-c]);
         check("hold_bit", m_bo, hb[11-c]);
         check("hold_busy", m_busy, 1'b1);
         step();
      end
      hold = 1'b0;
      mid();
      check("hold_end_bv", m_bv, 1'b0);
      check("hold_ws",     m_ws, 16'd5);
      step();
      $display("[TB] word C3 serialized with hold");

      // ---------------- reset mid-operation ----------------
      mv = 1'b1; md = 8'hF0;
      mid();
      step();
      md = 8'h0F;
      mid();
      check("mrst_bit1", m_bo, 1'b1);
      step();
      mv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid();
         check("mrst_bv", m_bv, 1'b1);
         check("mrst_bit", m_bo, 1'b1);
         check("mrst_ready_full", m_ready, 1'b0);
         step();
      end
      mid();
      check("mrst_bit5", m_bo, 1'b0);
      check("mrst_busy_pre", m_busy, 1'b1);
      rst = 1'b0;
      step();
      mid();
      check("mrst_bv",    m_bv,    1'b0);
      check("mrst_busy",  m_busy,  1'b0);
      check("mrst_ws",    m_ws,    16'd0);
      check("mrst_ready", m_ready, 1'b0);
      step();
      rst = 1'b1;
      mid();
      check("mrst_rel_busy",  m_busy,  1'b0);
      check("mrst_rel_ready", m_ready, 1'b1);
      step();
      mv = 1'b1; md = 8'h28;
      mid();
      step();
      mv = 1'b0;
      expect_m("post_rst", 8'b0010_1000);
      mid();
      check("post_rst_bv",   m_bv,   1'b0);
      check("post_rst_busy", m_busy, 1'b0);
      check("post_rst_ws",   m_ws,   16'd1);
      step();
      $display("[TB] reset mid-word, then word 28 serialized");

      // ---------------- LSB-first 8'h14 ----------------
      lseq = 8'b0010_1000;
      lv = 1'b1; ld = 8'h14;
      mid();
      check("lsb_ready", l_ready, 1'b1);
      step();
      lv = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mid();
         check("lsb_bv",  l_bv, 1'b1);
         check("lsb_bit", l_bo, lseq[7-i]);
         step();
      end
      mid();
      check("lsb_end_bv", l_bv, 1'b0);
      check("lsb_ws",     l_ws, 2'd1);
      step();
      $display("[TB] LSB-first word 14 serialized");

      // ---------------- counter wrap (2-bit counter, 4 words total) ----------------
      lv = 1'b1; ld = 8'h5A;
      accepts = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         mid();
         if (lv && l_ready) accepts++;
         step();
         if (accepts == 3) lv = 1'b0;
         if (accepts == 3 && !l_busy) done = 1'b1;
      end
      check("wrap_done", done, 1'b1);
      mid();
      check("wrap_ws", l_ws, 2'd0);
      step();
      $display("[TB] LSB instance counter wrap done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_stream_serializer.md
# bit_stream_serializer

Upstream feeder for the pattern detector. It accepts parallel words over a valid/ready handshake and serializes them into the single-bit `valid`/`in` stream that `pattern_det` consumes, one bit per clock. A one-word holding buffer keeps the bit stream gap-free across word boundaries. A `hold` input pauses emission without losing data.

## Interface
Parameters:
- `WIDTH`, 8, word width in bits (≥2)
- `MSB_FIRST`, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first
- `CNT_W`, 16, width of the `words_sent` counter

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge
- `rst`  input  1  synchronous, active-low reset (sampled on the `clk` rising edge)
- `word_valid`  input  1  producer has a word on `word_data`
- `word_data`  input  WIDTH  word to serialize
- `word_ready`  output  1  block can take a word this cycle
- `hold`  input  1  pause bit emission; acceptance into a free slot continues
- `bit_valid`  output  1  `bit_out` is a valid stream bit this cycle (drives `pattern_det` `valid`)
- `bit_out`  output  1  current stream bit (drives `pattern_det` `in`)
- `busy`  output  1  a word is in the shifter or the holding buffer
- `words_sent`  output  CNT_W  count of fully emitted words; wraps

## Operation
- State: shifter `sreg[WIDTH]`, bit index `cnt` (0..WIDTH-1), flag `active`, holding register `hbuf[WIDTH]`, flag `hfull`, counter `words_sent`.
- Combinational outputs:
  - `word_ready = rst & ~hfull`.
  - `bit_valid = active & ~hold`.
  - `bit_out` is `sreg[WIDTH-1]` when `MSB_FIRST`, else `sreg[0]`.
  - `busy = active | hfull`.
- A word is accepted on an edge where `word_valid & word_ready`.
- Shifter control is a two-state FSM:
  - **IDLE** (`active=0`): an accept loads `sreg` directly, sets `cnt=0` and goes to SHIFT. `hbuf` is untouched.
  - **SHIFT** (`active=1`): on an edge with `bit_valid`, shift `sreg` toward the output end and increment `cnt`.
- Last bit consumed (`bit_valid & cnt==WIDTH-1`):
  - `words_sent` increments; `cnt` goes to 0.
  - If `hfull`: load `sreg` from `hbuf`, clear `hfull`, stay in SHIFT.
  - Else if an accept happens on the same edge: load `sreg` from `word_data`, stay in SHIFT.
  - Else: return to IDLE.
- Accept in SHIFT when the last bit is not being consumed: write `hbuf`, set `hfull`.
- Accept while `hfull=1` cannot occur, because `word_ready` is low.
- `hold=1` freezes `sreg`, `cnt`, `active` and `words_sent`. An accept may still fill an empty `hbuf` (in SHIFT) or the shifter (in IDLE).
- `words_sent` wraps from 2^CNT_W−1 to 0.
- No backpressure from downstream: `pattern_det` consumes every `bit_valid` cycle.

## Timing
- Reset: `rst=0` at an edge clears `active`, `hfull`, `cnt`, `sreg`, `hbuf` and `words_sent`. Any partially shifted or buffered word is discarded.
- While `rst=0`: `word_ready=0`, `bit_valid=0`, `bit_out=0`, `busy=0`, `words_sent=0`.
- The first accept is possible on the first edge with `rst=1`.
- Latency: word accepted at edge N → its first bit on `bit_out` with `bit_valid=1` in the cycle after edge N, provided `hold=0`.
- Throughput: one word per WIDTH cycles. With `word_valid` held high, consecutive words produce contiguous `bit_valid` with zero gap cycles.
- After the first word enters the shifter, the second accept fills `hbuf`. `word_ready` then stays low until the edge on which the shifter reloads from `hbuf`.
- `hold` acts in the same cycle it is applied (combinational on `bit_valid`). Emission resumes in the cycle `hold` falls, at the same bit.
- `words_sent` updates on the edge that consumes the last bit, and is visible the next cycle.

## Test plan
- **Reset:** `rst=0` for 3 cycles with `word_valid=1` → all outputs 0 and no accept. After release, `word_ready=1` on the first cycle.
- **Single word:** 8'h28, `MSB_FIRST=1` → `bit_out` = 0,0,1,0,1,0,0,0 on 8 consecutive `bit_valid` cycles starting the cycle after the accept. Then `bit_valid=0`, `busy=0`, `words_sent=1`. A `pattern_det` fed from this stream reports 1 detection.
- **Back-to-back:** 8'hA5, 8'h3C, 8'hFF with `word_valid` held → 24 contiguous `bit_valid` cycles, bits 10100101 00111100 11111111. `word_ready` drops after the 2nd accept. `words_sent=3`.
- **Hold:** 8'hC3, with `hold=1` for 3 cycles after the 3rd bit → `bit_valid=0` for those 3 cycles. The stream resumes with bit 4 (0), nothing is duplicated or lost, and the word takes 11 cycles total.
- **Reset mid-operation:** `rst=0` during the 5th bit of 8'hF0, with 8'h0F held in `hbuf` → next cycle `bit_valid=0`, `busy=0`, `words_sent=0`. After release, a new 8'h28 serializes cleanly.
- **LSB-first:** `MSB_FIRST=0`, word 8'h14 → `bit_out` = 0,0,1,0,1,0,0,0. A downstream `pattern_det` reports 1 detection.
